// File: rtl/imem_loader.sv
// Boot loader for the 1024x32 instruction memory: length header + little-endian words
// from a byte stream, core held in reset until done. Option: IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int DEPTH_WORDS = 1024,
  parameter int CNT_W       = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        core_rst,
  output logic        busy,
  output logic        done,
  output logic        error
);
  localparam int WIDX_W = $clog2(DEPTH_WORDS) + 1;
  localparam logic [CNT_W:0] MAX_N = (CNT_W+1)'(DEPTH_WORDS);

  typedef enum logic [2:0] {IDLE, HDR_LO, HDR_HI, DATA, WRITE, CHK, DONE, ERR} state_t;

  state_t              state, state_nxt;
  logic [7:0]          hdr_lo;
  logic [CNT_W-1:0]    n_words;
  logic [WIDX_W-1:0]   widx;
  logic [1:0]          bsel;
  logic [23:0]         asm_w;
  logic [7:0]          csum;
  logic                xfer;
  logic [CNT_W-1:0]    hdr_n;
  logic [CNT_W:0]      widx_p1;
  logic                last_word;
  logic                restart;

  // byte_ready is registered, so a transfer is judged against the current state
  assign xfer      = byte_valid & byte_ready;
  assign hdr_n     = CNT_W'({byte_data, hdr_lo});
  assign widx_p1   = (CNT_W+1)'(widx) + 1'b1;
  assign last_word = (widx_p1 == {1'b0, n_words});
  assign restart   = start & ((state == IDLE) | (state == DONE) | (state == ERR));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE, ERR: if (start) state_nxt = HDR_LO;
      HDR_LO:          if (xfer) state_nxt = HDR_HI;
      HDR_HI: if (xfer) begin
        if (hdr_n == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_nxt = CHK;
`else
          state_nxt = DONE;
`endif
        end else if ({1'b0, hdr_n} > MAX_N) state_nxt = ERR;
        else                                 state_nxt = DATA;
      end
      DATA: if (xfer && bsel == 2'd3) state_nxt = WRITE;
      WRITE: begin
        if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_nxt = CHK;
`else
          state_nxt = DONE;
`endif
        end else state_nxt = DATA;
      end
      CHK: if (xfer) state_nxt = (byte_data == csum) ? DONE : ERR;
      default: state_nxt = IDLE;
    endcase
  end

  // datapath: header capture, word assembly, running XOR, word index
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hdr_lo    <= '0;
      n_words   <= '0;
      widx      <= '0;
      bsel      <= '0;
      asm_w     <= '0;
      csum      <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (restart) begin
      widx  <= '0;
      bsel  <= '0;
      asm_w <= '0;
      csum  <= '0;
    end else begin
      case (state)
        HDR_LO: if (xfer) hdr_lo <= byte_data;
        HDR_HI: if (xfer) n_words <= hdr_n;
        DATA: if (xfer) begin
          bsel <= bsel + 2'd1;
          csum <= csum ^ byte_data;
          if (bsel == 2'd3) begin
            mem_wdata <= {byte_data, asm_w};
            mem_addr  <= 32'({widx, 2'b00});
          end else begin
            asm_w[8*bsel +: 8] <= byte_data;
          end
        end
        WRITE: widx <= widx + 1'b1;
        default: ;
      endcase
    end
  end

  // outputs follow the next state so every output is a flop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_ready <= 1'b0;
      mem_we     <= 1'b0;
      core_rst   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      byte_ready <= (state_nxt == HDR_LO) | (state_nxt == HDR_HI) |
                    (state_nxt == DATA)   | (state_nxt == CHK);
      mem_we     <= (state_nxt == WRITE);
      core_rst   <= (state_nxt == DONE);
      busy       <= (state_nxt == HDR_LO) | (state_nxt == HDR_HI) | (state_nxt == DATA) |
                    (state_nxt == WRITE)  | (state_nxt == CHK);
      done       <= (state_nxt == DONE);
      error      <= (state_nxt == ERR);
    end
  end

endmodule
